md_joy_reader: RTL and testbench
================================

// Module: md_joy_reader
// PURPOSE
//  Polls the DB9 joystick port for the core's joystick input path. Scans an Atari
//    pad, a 3-button Mega Drive pad or a 6-button Mega Drive pad by driving select
//    (joyp7_o) through an 8-phase sequence.
//  Publishes one debounced-by-scan 12-bit button word, MXYZ SACB UDLR, active-high,
//    plus the detected pad type.
// PARAMETERS
//  CLK_MHZ   16'd50   clk frequency in MHz; all timing is derived from it
//  PHASE_US  16'd10   duration of each select phase, in us; must be >= 1
//  IDLE_US   16'd2000 select-high gap between scans, in us; must be >= 1600 for 6-button pad reset
// PORTS
//  clk        in   1   system clock; single clock domain
//  reset      in   1   synchronous, active-high reset
//  joyp1_i    in   1   DB9 pin 1, active-low
//  joyp2_i    in   1   DB9 pin 2, active-low
//  joyp3_i    in   1   DB9 pin 3, active-low
//  joyp4_i    in   1   DB9 pin 4, active-low
//  joyp6_i    in   1   DB9 pin 6, active-low
//  joyp9_i    in   1   DB9 pin 9, active-low
//  joyp7_o    out  1   pad select; idle level is 1
//  joy_out    out  12  [11]M [10]X [9]Y [8]Z [7]S [6]A [5]C [4]B [3]U [2]D [1]L [0]R; 1 = pressed
//  pad_type   out  2   00 Atari/none, 01 MD 3-button, 10 MD 6-button, 11 never driven
//  scan_done  out  1   1-cycle pulse on the cycle joy_out and pad_type update
// BEHAVIOUR
//  Reset values: joyp7_o=1, joy_out=0, pad_type=00, scan_done=0; FSM=IDLE; counters=0.
//  Reset asserted mid-scan aborts the scan; next cycle joyp7_o=1 and all outputs return to reset values.
//  Input sync: all six pins pass through a 2-FF synchronizer and are inverted internally
//    (pressed=1). Latency is 2 cycles, which fits inside any phase.
//  Derived constants: PHASE_CYC=CLK_MHZ*PHASE_US, IDLE_CYC=CLK_MHZ*IDLE_US.
//    Counter width is $clog2 of the larger value.
//  FSM: IDLE -> SCAN (p=0..7) -> IDLE.
//  IDLE: joyp7_o=1; counts IDLE_CYC cycles, then enters SCAN with p=0.
//  SCAN: joyp7_o=p[0], so phase 0 is low. Each phase lasts exactly PHASE_CYC cycles.
//    Synced pins are sampled on the last cycle of each phase (count==PHASE_CYC-1).
//  Sample map:
//    p0 (L): pins 3,4 both pressed -> md_det=1; pin6 -> A; pin9 -> S
//    p1 (H): pins 1,2,3,4,6,9 -> U,D,L,R,B,C
//    p2, p3: repeat p0/p1 (samples ignored)
//    p4 (L): pins 1-4 all pressed -> six_det=1
//    p5 (H): pins 1,2,3,4 -> Z,Y,X,M
//    p6, p7: ignored; pad reset phases
//  Commit on the last cycle of p7, all fields updated in that one cycle:
//    scan_done=1; FSM returns to IDLE with joyp7_o=1 on the following cycle.
//  Commit rules:
//    md_det=0 -> pad_type=00; joy_out={4'b0, 2'b0, C, B, U, D, L, R} from p1 (pin9 = C fire)
//    md_det=1, six_det=0 -> pad_type=01; M/X/Y/Z forced 0
//    md_det=1, six_det=1 -> pad_type=10; all 12 bits valid
//  Unplugged pad: pull-ups make every pin read released -> pad_type=00, joy_out=0. This is not an error.
//  Hot-plug mid-scan: the committed word may be inconsistent for that one scan; the next scan is correct.
//  Scan period: IDLE_CYC + 8*PHASE_CYC cycles, fixed and free-running. No external trigger.
// STRUCTURE
//  Shared package joy_pkg:
//    JOY_R=0 .. JOY_M=11 bit indices
//    PAD_ATARI=2'b00, PAD_MD3=2'b01, PAD_MD6=2'b10
//    NUM_PHASES=8
//  Sub-module joy_sync: parameterised-width 2-FF synchronizer with sync reset to all-1 (released).
//  Single FSM with phase counter and cycle counter; sample registers held apart from output
//    registers so outputs only change at commit.
// TESTING (sim params CLK_MHZ=1, PHASE_US=2, IDLE_US=40; bench pad models driven from joyp7_o)
//  Reset held 5 cycles -> joyp7_o=1, joy_out=12'h000, pad_type=00, scan_done=0.
//    First select fall occurs 40 cycles after release.
//  All pins high (no pad) -> joyp7_o low/high every 2 cycles x8, scan_done pulses once,
//    joy_out=12'h000, pad_type=00. Period between pulses is 56 cycles.
//  Atari model, pin1+pin6 held low -> joy_out=12'h018 (U,B), pad_type=00.
//  MD 3-button model, A+Start+Right pressed -> joy_out=12'h0C1, pad_type=01.
//  MD 6-button model, X+Mode+C pressed -> joy_out=12'hC20, pad_type=10.
//    Releasing all buttons gives 12'h000 after the next scan_done.
//  6-button pressing U; reset pulsed during p3 -> next cycle joyp7_o=1 and joy_out=0.
//    The next scan completes normally with joy_out=12'h008.

Source files
------------

// File: rtl/joy_pkg.sv
// Shared constants and types for the DB9 / Mega Drive joystick reader.
package joy_pkg;

  // Bit positions inside the published 12-bit button word (MXYZ SACB UDLR).
  localparam int JOY_R = 0;
  localparam int JOY_L = 1;
  localparam int JOY_D = 2;
  localparam int JOY_U = 3;
  localparam int JOY_B = 4;
  localparam int JOY_C = 5;
  localparam int JOY_A = 6;
  localparam int JOY_S = 7;
  localparam int JOY_Z = 8;
  localparam int JOY_Y = 9;
  localparam int JOY_X = 10;
  localparam int JOY_M = 11;

  // Detected pad type codes; 2'b11 is never produced.
  localparam logic [1:0] PAD_ATARI = 2'b00;
  localparam logic [1:0] PAD_MD3   = 2'b01;
  localparam logic [1:0] PAD_MD6   = 2'b10;

  // Number of select phases in one scan.
  localparam int NUM_PHASES = 8;

  // Positions of the DB9 input pins inside the internal 6-bit pin vector.
  localparam int NUM_PINS = 6;
  localparam int PIN1 = 0;
  localparam int PIN2 = 1;
  localparam int PIN3 = 2;
  localparam int PIN4 = 3;
  localparam int PIN6 = 4;
  localparam int PIN9 = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/joy_sync.sv
// Two-flop synchronizer for the asynchronous DB9 pins. Resets to all-ones,
// which is the released level of the active-low pad lines.
module joy_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  // Two-stage capture of the raw pins into the clk domain.
  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs from before the edge, forming a real two-flop chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      q      <= '1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/md_joy_reader.sv
// Scans an Atari, 3-button or 6-button Mega Drive pad through an 8-phase
// select sequence and publishes one button word per scan plus the pad type.
module md_joy_reader
  import joy_pkg::*;
#(
  parameter logic [15:0] CLK_MHZ  = 16'd50,
  parameter logic [15:0] PHASE_US = 16'd10,
  parameter logic [15:0] IDLE_US  = 16'd2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joyp1_i,
  input  logic        joyp2_i,
  input  logic        joyp3_i,
  input  logic        joyp4_i,
  input  logic        joyp6_i,
  input  logic        joyp9_i,
  output logic        joyp7_o,
  output logic [11:0] joy_out,
  output logic [1:0]  pad_type,
  output logic        scan_done
);

  localparam int unsigned PHASE_CYC = int'(CLK_MHZ) * int'(PHASE_US);
  localparam int unsigned IDLE_CYC  = int'(CLK_MHZ) * int'(IDLE_US);
  localparam int unsigned MAX_CYC   = (IDLE_CYC > PHASE_CYC) ? IDLE_CYC : PHASE_CYC;
  localparam int          CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYC - 1);
  localparam logic [2:0]       LAST_PHASE = 3'(NUM_PHASES - 1);

  // Synchronized pins, inverted so that 1 means pressed.
  logic [NUM_PINS-1:0] pins_sync;
  logic [NUM_PINS-1:0] pressed;

  joy_sync #(.WIDTH(NUM_PINS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({joyp9_i, joyp6_i, joyp4_i, joyp3_i, joyp2_i, joyp1_i}),
    .q     (pins_sync)
  );

  assign pressed = ~pins_sync;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       phase_q, phase_d;
  logic             strobe;
  logic             commit;

  // The sample strobe is delayed by the synchronizer depth so that the value
  // captured is the one the pins carried on the last cycle of each phase.
  logic       smp1_q, smp2_q;
  logic [2:0] smp_ph1_q, smp_ph2_q;

  // Per-scan sample registers, kept apart from the published outputs.
  logic       md_det_q, six_det_q, a_q, s_q;
  logic [5:0] p1_q;
  logic [3:0] p5_q;

  logic [11:0] word_d;
  logic [1:0]  type_d;

  // State, phase and cycle counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic, select drive, sample strobe and commit decode.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    joyp7_o = 1'b1;
    strobe  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cnt_q == IDLE_LAST) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          phase_d = '0;
        end
      end
      ST_SCAN: begin
        joyp7_o = phase_q[0];
        if (cnt_q == PHASE_LAST) begin
          cnt_d  = '0;
          strobe = 1'b1;
          if (phase_q == LAST_PHASE) begin
            commit  = 1'b1;
            state_d = ST_IDLE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Align the sample strobe and its phase tag with the synchronizer delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      smp1_q    <= 1'b0;
      smp2_q    <= 1'b0;
      smp_ph1_q <= '0;
      smp_ph2_q <= '0;
    end else begin
      smp1_q    <= strobe;
      smp2_q    <= smp1_q;
      smp_ph1_q <= phase_q;
      smp_ph2_q <= smp_ph1_q;
    end
  end

  // Capture the pins belonging to the phases that carry information.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_det_q  <= 1'b0;
      six_det_q <= 1'b0;
      a_q       <= 1'b0;
      s_q       <= 1'b0;
      p1_q      <= '0;
      p5_q      <= '0;
    end else if (smp2_q) begin
      case (smp_ph2_q)
        3'd0: begin
          md_det_q <= pressed[PIN3] & pressed[PIN4];
          a_q      <= pressed[PIN6];
          s_q      <= pressed[PIN9];
        end
        3'd1:    p1_q      <= pressed;
        3'd4:    six_det_q <= &pressed[PIN4:PIN1];
        3'd5:    p5_q      <= pressed[PIN4:PIN1];
        default: ;
      endcase
    end
  end

  // Assemble the button word and pad type from the samples of this scan.
  always_comb begin
    word_d        = '0;
    type_d        = PAD_ATARI;
    word_d[JOY_U] = p1_q[PIN1];
    word_d[JOY_D] = p1_q[PIN2];
    word_d[JOY_L] = p1_q[PIN3];
    word_d[JOY_R] = p1_q[PIN4];
    word_d[JOY_B] = p1_q[PIN6];
    word_d[JOY_C] = p1_q[PIN9];
    if (md_det_q) begin
      type_d        = PAD_MD3;
      word_d[JOY_A] = a_q;
      word_d[JOY_S] = s_q;
      if (six_det_q) begin
        type_d        = PAD_MD6;
        word_d[JOY_Z] = p5_q[PIN1];
        word_d[JOY_Y] = p5_q[PIN2];
        word_d[JOY_X] = p5_q[PIN3];
        word_d[JOY_M] = p5_q[PIN4];
      end
    end
  end

  // Published outputs change only at commit, all fields in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      joy_out   <= '0;
      pad_type  <= PAD_ATARI;
      scan_done <= 1'b0;
    end else begin
      scan_done <= commit;
      if (commit) begin
        joy_out  <= word_d;
        pad_type <= type_d;
      end
    end
  end

endmodule

// File: tb/tb_md_joy_reader.sv
// Self-checking bench: behavioural pad models driven from the select line,
// expected results queued per scan and compared by an independent monitor.
module tb_md_joy_reader;

  localparam int SCAN_PERIOD = 56;
  localparam int IDLE_CYCLES = 40;
  localparam int WAIT_BOUND  = 200;

  localparam int KIND_NONE  = 0;
  localparam int KIND_ATARI = 1;
  localparam int KIND_MD3   = 2;
  localparam int KIND_MD6   = 3;

  typedef struct packed {
    logic [11:0] word;
    logic [1:0]  ptype;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        joyp1_i, joyp2_i, joyp3_i, joyp4_i, joyp6_i, joyp9_i;
  logic        joyp7_o;
  logic [11:0] joy_out;
  logic [1:0]  pad_type;
  logic        scan_done;

  md_joy_reader #(
    .CLK_MHZ  (16'd1),
    .PHASE_US (16'd2),
    .IDLE_US  (16'd40)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .joyp1_i   (joyp1_i),
    .joyp2_i   (joyp2_i),
    .joyp3_i   (joyp3_i),
    .joyp4_i   (joyp4_i),
    .joyp6_i   (joyp6_i),
    .joyp9_i   (joyp9_i),
    .joyp7_o   (joyp7_o),
    .joy_out   (joy_out),
    .pad_type  (pad_type),
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- pad models ----------------
  int          pad_kind = KIND_NONE;
  logic [11:0] btn      = '0;   // pressed buttons in MXYZ SACB UDLR layout
  int          hi_cnt   = 0;
  int          lows     = 0;    // select falls since the pad last saw a long high

  always @(posedge clk) begin
    if (joyp7_o === 1'b1) hi_cnt++;
    else hi_cnt = 0;
  end

  always @(negedge joyp7_o) begin
    if (hi_cnt >= 10) lows = 1;
    else lows = lows + 1;
  end

  always_comb begin
    logic [5:0] pr;  // pressed pins {9,6,4,3,2,1}
    pr = '0;
    case (pad_kind)
      KIND_ATARI: pr = {btn[5], btn[4], btn[0], btn[1], btn[2], btn[3]};
      KIND_MD3, KIND_MD6: begin
        if (joyp7_o === 1'b0) begin
          if (pad_kind == KIND_MD6 && lows == 3)
            pr = {btn[7], btn[6], 4'b1111};
          else
            pr = {btn[7], btn[6], 2'b11, btn[2], btn[3]};
        end else begin
          if (pad_kind == KIND_MD6 && lows == 3)
            pr = {btn[5], btn[4], btn[11], btn[10], btn[9], btn[8]};
          else
            pr = {btn[5], btn[4], btn[0], btn[1], btn[2], btn[3]};
        end
      end
      default: pr = '0;
    endcase
    {joyp9_i, joyp6_i, joyp4_i, joyp3_i, joyp2_i, joyp1_i} = ~pr;
  end

  // Reference model: which buttons each pad type can report.
  function automatic exp_t expected(input int kind, input logic [11:0] b);
    exp_t e;
    case (kind)
      KIND_ATARI: begin e.word = b & 12'h03F; e.ptype = 2'b00; end
      KIND_MD3:   begin e.word = b & 12'h0FF; e.ptype = 2'b01; end
      KIND_MD6:   begin e.word = b;           e.ptype = 2'b10; end
      default:    begin e.word = 12'h000;     e.ptype = 2'b00; end
    endcase
    return e;
  endfunction

  task automatic set_pad(input int kind, input logic [11:0] b);
    pad_kind = kind;
    btn      = b;
    exp_q.push_back(expected(kind, b));
  endtask

  // ---------------- monitor ----------------
  int   cyc       = 0;
  int   last_cyc  = 0;
  bit   have_last = 0;
  exp_t mon_e;

  always @(posedge clk) begin
    cyc++;
    if (reset) have_last = 0;
    #1;
    if (scan_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("scan_done_expected", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("joy_out", joy_out, mon_e.word);
        check("pad_type", pad_type, mon_e.ptype);
      end
      if (have_last) check("scan_period", cyc - last_cyc, SCAN_PERIOD);
      last_cyc  = cyc;
      have_last = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_fall(output int k);
    k = 0;
    while (k < WAIT_BOUND) begin
      @(negedge clk);
      k++;
      if (joyp7_o === 1'b0) break;
    end
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < WAIT_BOUND; i++) begin
      @(negedge clk);
      if (scan_done === 1'b1) begin
        got = 1;
        break;
      end
    end
    check("scan_done_seen", got, 1);
  endtask

  initial begin
    int          k;
    logic [15:0] trace, trace_exp;
    int          kind;
    logic [11:0] b;

    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_joyp7_o", joyp7_o, 1);
    check("rst_joy_out", joy_out, 12'h000);
    check("rst_pad_type", pad_type, 2'b00);
    check("rst_scan_done", scan_done, 0);

    // No pad: check idle length and select waveform of the first scan.
    set_pad(KIND_NONE, 12'h000);
    reset = 1'b0;
    wait_fall(k);
    check("first_fall_cycles", k, IDLE_CYCLES);
    trace     = '0;
    trace_exp = '0;
    trace[0]  = joyp7_o;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      trace[i] = joyp7_o;
    end
    for (int i = 0; i < 16; i++) trace_exp[i] = ((i >> 1) & 1) != 0;
    check("select_trace", trace, trace_exp);
    wait_done();

    set_pad(KIND_NONE, 12'h000);   // second empty scan establishes the period
    wait_done();
    set_pad(KIND_ATARI, 12'h018);  // U + B
    wait_done();
    set_pad(KIND_MD3, 12'h0C1);    // A + Start + Right
    wait_done();
    set_pad(KIND_MD6, 12'hC20);    // X + Mode + C
    wait_done();
    set_pad(KIND_MD6, 12'h000);    // all released
    wait_done();

    for (int n = 0; n < 12; n++) begin
      kind = int'($urandom_range(0, 3));
      b    = 12'($urandom);
      if (kind == KIND_ATARI && b[1] && b[0]) b[0] = 1'b0;  // L+R looks like an MD pad
      if (kind == KIND_MD3 && b[3] && b[2]) b[2] = 1'b0;    // U+D looks like a 6-button pad
      set_pad(kind, b);
      wait_done();
    end

    // 6-button with U held; reset pulsed during phase 3 aborts the scan.
    set_pad(KIND_MD6, 12'h008);
    wait_done();
    wait_fall(k);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_joyp7_o", joyp7_o, 1);
    check("abort_joy_out", joy_out, 12'h000);
    check("abort_pad_type", pad_type, 2'b00);
    check("abort_scan_done", scan_done, 0);
    set_pad(KIND_MD6, 12'h008);
    wait_fall(k);
    check("refall_cycles", k, IDLE_CYCLES);
    wait_done();

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
